// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and sizing for the branch resolve unit.
// Holds the in-flight queue entry layout and PHT parameters.
package branch_resolve_unit_pkg;

    localparam int QUEUE_DEPTH = 4;
    localparam int PHT_IDX_W   = 10;
    localparam int PHT_SIZE    = 1 << PHT_IDX_W;
    localparam int PC_W        = 32;
    localparam int CNT_W       = 16;

    localparam logic [1:0] CTR_INIT = 2'b01;

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic                 choice;
        logic [PC_W-1:0]      next_pc;
        logic [PHT_IDX_W-1:0] idx;
    } br_entry_t;

    function automatic logic [1:0] ctr_next(
        input logic [1:0] c,
        input logic       taken
    );
        logic [1:0] n;
        n = c;
        if (taken && c != 2'b11) n = c + 2'b01;
        if (!taken && c != 2'b00) n = c - 2'b01;
        return n;
    endfunction

endpackage

// File: rtl/branch_info_fifo.sv
// In-flight branch info queue, oldest entry visible at pop_data.
// Flush empties it and wins over any push on the same edge.
module branch_info_fifo
    import branch_resolve_unit_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      push,
    input  br_entry_t push_data,
    input  logic      pop,
    output br_entry_t pop_data,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);

    br_entry_t        mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt == (PTR_W+1)'(QUEUE_DEPTH));
    assign empty    = (cnt == '0);
    assign do_pop   = pop && !empty;
    // A full queue still accepts a push when the head leaves together.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks fetched predictions, resolves them in order against EX,
// trains a gshare PHT and emits the BTB update/redirect bundle.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_valid,
    input  logic [PC_W-1:0]  fetch_PC,
    input  logic             fetch_Choice,
    input  logic [PC_W-1:0]  fetch_NEXT_PC,
    input  logic [PC_W-1:0]  PC_lookup,
    input  logic             ex_valid,
    input  logic             ex_is_Branch,
    input  logic             ex_is_Jump,
    input  logic             ex_Taken,
    input  logic [PC_W-1:0]  ex_Target,
    output logic             Gpre,
    output logic             update_En,
    output logic             is_Branch,
    output logic             is_Jump,
    output logic             old_Choice,
    output logic             update_Choice,
    output logic             Remedy,
    output logic [PC_W-1:0]  old_PC,
    output logic [PC_W-1:0]  check_Addr,
    output logic             stall_fetch,
    output logic [CNT_W-1:0] mispredict_cnt
);

    logic [1:0]           pht [PHT_SIZE];
    logic [PHT_IDX_W-1:0] ghr;
    logic [PHT_IDX_W-1:0] look_idx;

    br_entry_t       enq_data;
    br_entry_t       head;
    logic            full;
    logic            empty;
    logic            deq;
    logic            enq;
    logic            flush;
    logic            redirect;
    logic [PC_W-1:0] actual_next;
    logic            unused_bits;

    assign unused_bits = ^{PC_lookup[PC_W-1:PHT_IDX_W+2],
                           PC_lookup[1:0],
                           fetch_PC[1:0]};

    assign look_idx = PC_lookup[PHT_IDX_W+1:2] ^ ghr;
    assign Gpre     = pht[look_idx][1];

    assign deq         = ex_valid && !empty;
    assign redirect    = ex_is_Jump || (ex_is_Branch && ex_Taken);
    assign actual_next = redirect ? ex_Target : head.pc + 32'd4;
    assign flush       = deq && (actual_next != head.next_pc);

    // Remedy high means this cycle's fetch is still on the wrong path.
    assign enq = fetch_valid && !flush && !Remedy;

    assign enq_data.pc      = fetch_PC;
    assign enq_data.choice  = fetch_Choice;
    assign enq_data.next_pc = fetch_NEXT_PC;
    assign enq_data.idx     = fetch_PC[PHT_IDX_W+1:2] ^ ghr;

    assign stall_fetch = full;

    branch_info_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (enq),
        .push_data (enq_data),
        .pop       (deq),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_SIZE; i++) pht[i] <= CTR_INIT;
        end else if (deq && ex_is_Branch) begin
            pht[head.idx] <= ctr_next(pht[head.idx], ex_Taken);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (deq && ex_is_Branch) begin
            ghr <= {ghr[PHT_IDX_W-2:0], ex_Taken};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            update_En      <= 1'b0;
            is_Branch      <= 1'b0;
            is_Jump        <= 1'b0;
            old_Choice     <= 1'b0;
            update_Choice  <= 1'b0;
            Remedy         <= 1'b0;
            old_PC         <= '0;
            check_Addr     <= '0;
            mispredict_cnt <= '0;
        end else begin
            update_En <= deq;
            Remedy    <= flush;
            if (deq) begin
                is_Branch     <= ex_is_Branch;
                is_Jump       <= ex_is_Jump;
                old_Choice    <= head.choice;
                update_Choice <= ex_is_Jump || ex_Taken;
                old_PC        <= head.pc;
                check_Addr    <= ex_Target;
            end
            if (flush) mispredict_cnt <= mispredict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed
// expectations for queueing, redirect, PHT training and reset.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_PC = '0;
    logic        fetch_Choice = 1'b0;
    logic [31:0] fetch_NEXT_PC = '0;
    logic [31:0] PC_lookup = 32'h300;
    logic        ex_valid = 1'b0;
    logic        ex_is_Branch = 1'b0;
    logic        ex_is_Jump = 1'b0;
    logic        ex_Taken = 1'b0;
    logic [31:0] ex_Target = '0;
    logic        Gpre;
    logic        update_En;
    logic        is_Branch;
    logic        is_Jump;
    logic        old_Choice;
    logic        update_Choice;
    logic        Remedy;
    logic [31:0] old_PC;
    logic [31:0] check_Addr;
    logic        stall_fetch;
    logic [15:0] mispredict_cnt;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_valid    (fetch_valid),
        .fetch_PC       (fetch_PC),
        .fetch_Choice   (fetch_Choice),
        .fetch_NEXT_PC  (fetch_NEXT_PC),
        .PC_lookup      (PC_lookup),
        .ex_valid       (ex_valid),
        .ex_is_Branch   (ex_is_Branch),
        .ex_is_Jump     (ex_is_Jump),
        .ex_Taken       (ex_Taken),
        .ex_Target      (ex_Target),
        .Gpre           (Gpre),
        .update_En      (update_En),
        .is_Branch      (is_Branch),
        .is_Jump        (is_Jump),
        .old_Choice     (old_Choice),
        .update_Choice  (update_Choice),
        .Remedy         (Remedy),
        .old_PC         (old_PC),
        .check_Addr     (check_Addr),
        .stall_fetch    (stall_fetch),
        .mispredict_cnt (mispredict_cnt)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic fv, input logic [31:0] pc,
                       input logic ch, input logic [31:0] np,
                       input logic ev, input logic br,
                       input logic jp, input logic tk,
                       input logic [31:0] tg);
        fetch_valid   = fv;
        fetch_PC      = pc;
        fetch_Choice  = ch;
        fetch_NEXT_PC = np;
        ex_valid      = ev;
        ex_is_Branch  = br;
        ex_is_Jump    = jp;
        ex_Taken      = tk;
        ex_Target     = tg;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic ch,
                         input logic [31:0] np);
        cyc(1'b1, pc, ch, np, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic resolve(input logic br, input logic jp,
                           input logic tk, input logic [31:0] tg);
        cyc(1'b0, '0, 1'b0, '0, 1'b1, br, jp, tk, tg);
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin : stim
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h604;
        exp_pc[1] = 32'h608;
        exp_pc[2] = 32'h60C;
        exp_pc[3] = 32'h614;

        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
        check("rst_upd", 32'(update_En), 32'd0);
        check("rst_remedy", 32'(Remedy), 32'd0);
        check("rst_stall", 32'(stall_fetch), 32'd0);
        check("rst_gpre", 32'(Gpre), 32'd0);
        check("rst_cnt", 32'(mispredict_cnt), 32'd0);
        check("rst_oldpc", old_PC, 32'd0);
        check("rst_chk", check_Addr, 32'd0);

        // simple non-branch, correctly predicted
        fetch(32'h100, 1'b0, 32'h104);
        resolve(1'b0, 1'b0, 1'b0, 32'h0);
        check("nb_upd", 32'(update_En), 32'd1);
        check("nb_remedy", 32'(Remedy), 32'd0);
        check("nb_oldpc", old_PC, 32'h100);
        check("nb_empty", 32'(dut.u_fifo.empty), 32'd1);
        resolve(1'b0, 1'b0, 1'b0, 32'h0);
        check("empty_ex_upd", 32'(update_En), 32'd0);
        check("empty_ex_hold", old_PC, 32'h100);

        // taken branch predicted not-taken
        fetch(32'h200, 1'b0, 32'h204);
        fetch(32'h204, 1'b0, 32'h208);
        cyc(1'b1, 32'h208, 1'b0, 32'h20C,
            1'b1, 1'b1, 1'b0, 1'b1, 32'h400);
        check("mp_remedy", 32'(Remedy), 32'd1);
        check("mp_uchoice", 32'(update_Choice), 32'd1);
        check("mp_chk", check_Addr, 32'h400);
        check("mp_isbr", 32'(is_Branch), 32'd1);
        check("mp_oldpc", old_PC, 32'h200);
        check("mp_empty", 32'(dut.u_fifo.empty), 32'd1);
        check("mp_cnt", 32'(mispredict_cnt), 32'd1);
        check("mp_ghr", 32'(dut.ghr), 32'h001);
        check("mp_pht", 32'(dut.pht[10'h080]), 32'd2);
        fetch(32'h500, 1'b0, 32'h504);
        check("wp_remedy", 32'(Remedy), 32'd0);
        check("wp_upd", 32'(update_En), 32'd0);
        check("wp_empty", 32'(dut.u_fifo.empty), 32'd1);

        // fill the queue
        fetch(32'h600, 1'b0, 32'h604);
        fetch(32'h604, 1'b0, 32'h608);
        fetch(32'h608, 1'b0, 32'h60C);
        check("fill3_stall", 32'(stall_fetch), 32'd0);
        fetch(32'h60C, 1'b0, 32'h610);
        check("full_stall", 32'(stall_fetch), 32'd1);
        fetch(32'h610, 1'b0, 32'h614);
        check("drop_stall", 32'(stall_fetch), 32'd1);
        check("drop_upd", 32'(update_En), 32'd0);
        cyc(1'b1, 32'h614, 1'b0, 32'h618,
            1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("both_stall", 32'(stall_fetch), 32'd1);
        check("both_oldpc", old_PC, 32'h600);
        check("both_remedy", 32'(Remedy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            resolve(1'b0, 1'b0, 1'b0, 32'h0);
            check($sformatf("drain%0d_pc", i), old_PC, exp_pc[i]);
            check($sformatf("drain%0d_rm", i), 32'(Remedy), 32'd0);
        end
        check("drain_empty", 32'(dut.u_fifo.empty), 32'd1);
        check("drain_stall", 32'(stall_fetch), 32'd0);

        // PHT training for one branch index
        rst = 1'b1;
        idle();
        rst = 1'b0;
        check("r2_gpre", 32'(Gpre), 32'd0);
        fetch(32'h300, 1'b1, 32'h380);
        fetch(32'h300, 1'b1, 32'h380);
        fetch(32'h340, 1'b1, 32'h800);
        fetch(32'h300, 1'b1, 32'h380);
        resolve(1'b1, 1'b0, 1'b1, 32'h380);
        check("pht_a", 32'(dut.pht[10'h0C0]), 32'd2);
        check("pht_a_rm", 32'(Remedy), 32'd0);
        check("pht_a_oc", 32'(old_Choice), 32'd1);
        resolve(1'b1, 1'b0, 1'b1, 32'h380);
        check("pht_b", 32'(dut.pht[10'h0C0]), 32'd3);
        resolve(1'b0, 1'b1, 1'b1, 32'h800);
        check("jmp_ghr", 32'(dut.ghr), 32'h003);
        check("jmp_pht", 32'(dut.pht[10'h0C0]), 32'd3);
        check("jmp_rm", 32'(Remedy), 32'd0);
        resolve(1'b1, 1'b0, 1'b1, 32'h380);
        check("pht_c", 32'(dut.pht[10'h0C0]), 32'd3);
        check("pht_ghr", 32'(dut.ghr), 32'h007);
        for (int i = 0; i < 10; i++) begin
            fetch(32'h900, 1'b0, 32'h904);
            resolve(1'b1, 1'b0, 1'b0, 32'hA00);
        end
        check("nt_uchoice", 32'(update_Choice), 32'd0);
        check("nt_chk", check_Addr, 32'hA00);
        check("nt_rm", 32'(Remedy), 32'd0);
        check("nt_ghr", 32'(dut.ghr), 32'h000);
        check("gpre_trained", 32'(Gpre), 32'd1);

        // PC+4 wraps to zero
        fetch(32'hFFFF_FFFC, 1'b0, 32'h0);
        resolve(1'b0, 1'b0, 1'b0, 32'h1234);
        check("wrap_upd", 32'(update_En), 32'd1);
        check("wrap_rm", 32'(Remedy), 32'd0);
        check("wrap_chk", check_Addr, 32'h1234);

        // unpredicted jump
        fetch(32'h700, 1'b0, 32'h704);
        resolve(1'b0, 1'b1, 1'b0, 32'h900);
        check("jmp_mp_rm", 32'(Remedy), 32'd1);
        check("jmp_mp_isj", 32'(is_Jump), 32'd1);
        check("jmp_mp_uch", 32'(update_Choice), 32'd1);
        check("jmp_mp_cnt", 32'(mispredict_cnt), 32'd1);
        check("jmp_mp_ghr", 32'(dut.ghr), 32'h000);
        idle();

        // reset with traffic in flight
        fetch(32'hB00, 1'b0, 32'hB04);
        fetch(32'hB04, 1'b0, 32'hB08);
        fetch(32'hB08, 1'b0, 32'hB0C);
        rst = 1'b1;
        cyc(1'b1, 32'hB0C, 1'b0, 32'hB10,
            1'b1, 1'b1, 1'b0, 1'b1, 32'hC00);
        rst = 1'b0;
        check("rr_upd", 32'(update_En), 32'd0);
        check("rr_rm", 32'(Remedy), 32'd0);
        check("rr_empty", 32'(dut.u_fifo.empty), 32'd1);
        check("rr_pht", 32'(dut.pht[10'h0C0]), 32'd1);
        check("rr_pht2", 32'(dut.pht[10'h247]), 32'd1);
        check("rr_cnt", 32'(mispredict_cnt), 32'd0);
        check("rr_oldpc", old_PC, 32'd0);
        check("rr_gpre", 32'(Gpre), 32'd0);
        idle();
        check("rr_idle_upd", 32'(update_En), 32'd0);
        check("rr_idle_stall", 32'(stall_fetch), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
